// File: rtl/lcd_write_arbiter.sv
// -----------------------------------------------------------------------------
// lcd_write_arbiter
//
// Shares one character-LCD bus between two write requesters. Each accepted
// write runs through SETUP (E low, RS/DATA stable), PULSE (E high), HOLD
// (E low, RS/DATA held) and WAIT (controller execution time). When both
// requesters wait in IDLE, the one that did not win last time is selected.
//
// Parameters
//   SETUP_CYC    cycles RS/DATA are stable before E rises        (>= 1)
//   PULSE_CYC    cycles E is high                                (>= 1)
//   HOLD_CYC     cycles RS/DATA are held after E falls           (>= 1)
//   CMD_WAIT_CYC execution wait after a normal command/data write (>= 1)
//   CLR_WAIT_CYC execution wait after clear/home (cmd 0x01..0x03) (>= 1)
//
// Ports
//   clk                 system clock
//   rst                 synchronous, active-high reset
//   reqN_valid          requester N has a write pending (held until ready)
//   reqN_rs             requester N register select (0 command, 1 data)
//   reqN_data           requester N byte
//   reqN_ready          requester N write accepted this cycle
//   LCD_E               LCD enable (registered, high only in PULSE)
//   LCD_RS              LCD register select (holds last written value)
//   LCD_RW              LCD read/write, tied to write (0)
//   LCD_DATA            LCD data bus (holds last written value)
//   busy                high whenever a write is in progress
//   grant_id            index of the most recently accepted requester
// -----------------------------------------------------------------------------
module lcd_write_arbiter #(
  parameter int SETUP_CYC    = 2,
  parameter int PULSE_CYC    = 4,
  parameter int HOLD_CYC     = 2,
  parameter int CMD_WAIT_CYC = 40,
  parameter int CLR_WAIT_CYC = 160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  // Counters are loaded with (length - 1) so a phase ends on the cycle the
  // counter reads zero.
  localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
  localparam logic [15:0] PULSE_LD = 16'(PULSE_CYC - 1);
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] CMD_LD   = 16'(CMD_WAIT_CYC - 1);
  localparam logic [15:0] CLR_LD   = 16'(CLR_WAIT_CYC - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [15:0] r_wait_ld;
  logic        r_last_grant;
  logic        r_grant_id;
  logic        r_lcd_e;
  logic        r_lcd_rs;
  logic [7:0]  r_lcd_data;

  logic        w_idle;
  logic        w_sel;
  logic        w_ready0;
  logic        w_ready1;
  logic        w_accept;
  logic        w_acc_rs;
  logic [7:0]  w_acc_data;
  logic        w_is_clr;

  // ---------------------------------------------------------------------------
  // Arbitration (combinational, IDLE only). Ready is masked during reset so a
  // requester never sees an accept that the reset would immediately discard.
  // ---------------------------------------------------------------------------
  assign w_idle     = (r_state == S_IDLE) && !rst;
  assign w_sel      = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign w_ready0   = w_idle && req0_valid && !w_sel;
  assign w_ready1   = w_idle && req1_valid &&  w_sel;
  assign w_accept   = w_ready0 || w_ready1;
  assign w_acc_rs   = w_sel ? req1_rs   : req0_rs;
  assign w_acc_data = w_sel ? req1_data : req0_data;

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign w_is_clr = !w_acc_rs &&
                    ((w_acc_data == 8'h01) || (w_acc_data == 8'h02) ||
                     (w_acc_data == 8'h03));

  // ---------------------------------------------------------------------------
  // Next-state / counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (r_cnt == 16'd0) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = PULSE_LD;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_PULSE: begin
        if (r_cnt == 16'd0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = HOLD_LD;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_HOLD: begin
        if (r_cnt == 16'd0) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = r_wait_ld;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_WAIT: begin
        if (r_cnt == 16'd0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 16'd0;
      r_wait_ld    <= 16'd0;
      r_last_grant <= 1'b1;  // requester 0 wins the first tie
      r_grant_id   <= 1'b0;
      r_lcd_e      <= 1'b0;
      r_lcd_rs     <= 1'b0;
      r_lcd_data   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // Registered E tracks the state being entered, so it is high exactly
      // for the cycles spent in PULSE.
      r_lcd_e <= (w_state_nxt == S_PULSE);
      if (w_accept) begin
        r_lcd_rs     <= w_acc_rs;
        r_lcd_data   <= w_acc_data;
        r_last_grant <= w_sel;
        r_grant_id   <= w_sel;
        r_wait_ld    <= w_is_clr ? CLR_LD : CMD_LD;
      end
    end
  end

  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign LCD_E      = r_lcd_e;
  assign LCD_RS     = r_lcd_rs;
  assign LCD_RW     = 1'b0;
  assign LCD_DATA   = r_lcd_data;
  assign busy       = (r_state != S_IDLE);
  assign grant_id   = r_grant_id;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lcd_write_arbiter
//
// Directed scenarios followed by randomized requester traffic. A transaction
// model (arbiter free-at cycle, last grant, expected E window) predicts ready,
// busy and the LCD pins every cycle; each predicted write is pushed into a
// scoreboard queue and popped by a monitor at each rising edge of LCD_E.
// -----------------------------------------------------------------------------
module tb_lcd_write_arbiter;

  localparam int S    = 2;
  localparam int P    = 4;
  localparam int H    = 2;
  localparam int CMDW = 40;
  localparam int CLRW = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic       req0_rs = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic       req1_rs = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;
  logic       busy;
  logic       grant_id;

  always #5 clk = ~clk;

  lcd_write_arbiter #(
    .SETUP_CYC   (S),
    .PULSE_CYC   (P),
    .HOLD_CYC    (H),
    .CMD_WAIT_CYC(CMDW),
    .CLR_WAIT_CYC(CLRW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_rs   (req0_rs),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_rs   (req1_rs),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .LCD_E     (LCD_E),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .LCD_DATA  (LCD_DATA),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  typedef struct {
    bit         id;
    bit         rs;
    logic [7:0] data;
    int         e_start;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Transaction-level model of the arbiter.
  bit         m_valid   = 1'b0;  // model in sync (a reset has been seen)
  int         m_free_at = 0;     // first cycle the bus is idle again
  bit         m_last    = 1'b1;
  bit         m_gid     = 1'b0;
  bit         m_rs      = 1'b0;
  logic [7:0] m_data    = 8'h00;
  int         m_e_lo    = 1;
  int         m_e_hi    = 0;
  bit         acc0      = 1'b0;
  bit         acc1      = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: compare the DUT against the model, then advance the
  // model with this cycle's inputs. Inputs change #1 after the next posedge.
  task automatic step();
    bit exp_busy, e_r0, e_r1, is_clr;
    int w;
    @(negedge clk);
    #1;
    exp_busy = (cyc < m_free_at);
    e_r0 = !rst && !exp_busy && req0_valid && (!req1_valid || m_last);
    e_r1 = !rst && !exp_busy && req1_valid && (!req0_valid || !m_last);
    check("req0_ready", 32'(req0_ready), 32'(e_r0));
    check("req1_ready", 32'(req1_ready), 32'(e_r1));
    if (m_valid) begin
      check("busy",     32'(busy),     32'(exp_busy));
      check("lcd_e",    32'(LCD_E),    32'(cyc >= m_e_lo && cyc <= m_e_hi));
      check("lcd_rs",   32'(LCD_RS),   32'(m_rs));
      check("lcd_data", 32'(LCD_DATA), 32'(m_data));
      check("lcd_rw",   32'(LCD_RW),   32'(0));
      check("grant_id", 32'(grant_id), 32'(m_gid));
    end
    acc0 = e_r0;
    acc1 = e_r1;
    if (rst) begin
      m_valid   = 1'b1;
      m_free_at = cyc + 1;
      m_last    = 1'b1;
      m_gid     = 1'b0;
      m_rs      = 1'b0;
      m_data    = 8'h00;
      m_e_lo    = 1;
      m_e_hi    = 0;
      sb.delete();
    end else if (e_r0 || e_r1) begin
      m_gid  = e_r1;
      m_last = e_r1;
      m_rs   = e_r1 ? req1_rs : req0_rs;
      m_data = e_r1 ? req1_data : req0_data;
      is_clr = !m_rs && (m_data >= 8'h01) && (m_data <= 8'h03);
      w      = is_clr ? CLRW : CMDW;
      m_e_lo = cyc + 1 + S;
      m_e_hi = cyc + S + P;
      m_free_at = cyc + 1 + S + P + H + w;
      sb.push_back('{id: e_r1, rs: m_rs, data: m_data, e_start: m_e_lo});
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Scoreboard monitor: every E pulse must be a predicted write.
  initial begin
    bit   prev_e = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (LCD_E === 1'b1 && !prev_e) begin
        if (sb.size() == 0) begin
          check("e_pulse_unexpected", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          check("sb_e_start", 32'(cyc),      32'(e.e_start));
          check("sb_rs",      32'(LCD_RS),   32'(e.rs));
          check("sb_data",    32'(LCD_DATA), 32'(e.data));
          check("sb_grant",   32'(grant_id), 32'(e.id));
        end
      end
      prev_e = (LCD_E === 1'b1);
    end
  end

  initial begin
    // Reset with both requesters valid, then continuous tie: 0,1,0 grants.
    rst = 1'b1;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h42;
    steps(2);
    rst = 1'b0;
    steps(3 * 49 + 2);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < 300 && cyc < m_free_at; k++) step();
    steps(2);

    // Single data write.
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h39;
    step();
    req0_valid = 1'b0;
    steps(55);

    // Clear command with a second command queued behind it.
    req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h01;
    step();
    req1_valid = 1'b0;
    steps(10);
    req0_valid = 1'b1; req0_rs = 1'b0; req0_data = 8'h0F;
    acc0 = 1'b0;
    for (int k = 0; k < 300 && !acc0; k++) step();
    req0_valid = 1'b0;
    steps(55);

    // Late arrival of requester 1 during requester 0's write.
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h20;
    step();
    req0_valid = 1'b0;
    steps(9);
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h21;
    acc1 = 1'b0;
    for (int k = 0; k < 100 && !acc1; k++) step();
    req1_valid = 1'b0;
    steps(55);

    // Reset in the middle of the E pulse; no further pulse afterwards.
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h55;
    step();
    req0_valid = 1'b0;
    steps(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(60);

    // Randomized traffic with occasional resets.
    acc0 = 1'b0;
    acc1 = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (acc0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 2) == 0);
        req0_rs    = 1'($urandom_range(0, 1));
        req0_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4))
                                                 : 8'($urandom);
      end
      if (acc1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 2) == 0);
        req1_rs    = 1'($urandom_range(0, 1));
        req1_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4))
                                                 : 8'($urandom);
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    steps(200);
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

Shares the single character-LCD bus between two write requesters, for example the keypad/cursor writer and a status/line writer. It sequences each accepted write through the LCD's setup, enable-pulse, hold and execution-wait phases. It arbitrates round-robin when both requesters are waiting and drives LCD_E/LCD_RS/LCD_RW/LCD_DATA directly. It sits between the requesting text-LCD logic and the LCD pins, replacing any per-requester E-pulse generation.

## Interface
- SETUP_CYC, 2: cycles RS/DATA are stable with E low before the E pulse (≥1)
- PULSE_CYC, 4: cycles E is high (≥1)
- HOLD_CYC, 2: cycles RS/DATA are held with E low after the E pulse (≥1)
- CMD_WAIT_CYC, 40: execution wait after a normal command or data write (≥1)
- CLR_WAIT_CYC, 160: execution wait after a clear or home command (≥1)
- clk  in  1  system clock; one clock domain for the whole block
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a write pending
- req0_rs  in  1  requester 0 register select: 0 = command, 1 = data
- req0_data  in  8  requester 0 byte
- req0_ready  out  1  requester 0 write is accepted this cycle
- req1_valid, req1_rs, req1_data, req1_ready: same as requester 0, for requester 1
- LCD_E  out  1  LCD enable
- LCD_RS  out  1  LCD register select
- LCD_RW  out  1  LCD read/write; constant 0 (write only)
- LCD_DATA  out  8  LCD data bus
- busy  out  1  high whenever state ≠ IDLE
- grant_id  out  1  index of the most recently accepted requester

## Operation
- State machine: IDLE → SETUP → PULSE → HOLD → WAIT → IDLE.
- Each timed state uses one 16-bit down-counter, loaded on state entry. The state is left when the counter reaches its last cycle.
- Arbitration is combinational, in IDLE only:
  - only one valid: that requester is selected;
  - both valid: the requester ≠ last_grant is selected.
- reqN_ready = (state==IDLE) & selected==N & reqN_valid. Ready is never high while busy.
- Accept occurs when valid & ready. On accept:
  - rs and data are latched into the LCD_RS/LCD_DATA registers;
  - last_grant/grant_id is updated;
  - the wait length is chosen.
- Wait length:
  - CLR_WAIT_CYC when rs=0 and data ∈ {0x01, 0x02, 0x03};
  - otherwise CMD_WAIT_CYC.
- Requesters hold valid/rs/data stable until ready. The arbiter never drops an accepted write.
- LCD_RS/LCD_DATA hold the last written value through IDLE until the next accept.
- LCD_E is a register, high only in PULSE.
- Reset values:
  - LCD_E = 0, LCD_RS = 0, LCD_RW = 0, LCD_DATA = 0x00;
  - busy = 0, grant_id = 0;
  - last_grant internally = 1, so requester 0 wins the first tie;
  - state = IDLE, counter = 0.
- Reset mid-operation (any state): the next cycle is IDLE with all outputs at reset values. An in-flight write is abandoned and not retried; its requester already saw ready.

## Timing
- Accept in cycle t (IDLE).
  - t+1: LCD_RS/LCD_DATA show the new value; SETUP starts.
  - LCD_E is high on cycles t+1+SETUP_CYC through t+SETUP_CYC+PULSE_CYC.
  - HOLD, then WAIT follow.
  - busy is high from t+1 to t+SETUP_CYC+PULSE_CYC+HOLD_CYC+wait.
  - Next possible accept is t+1+SETUP_CYC+PULSE_CYC+HOLD_CYC+wait.
- Defaults:
  - normal write: E high t+3..t+6, busy t+1..t+48, next accept t+49;
  - clear/home: busy t+1..t+168, next accept t+169.
- Ready is combinational from valid with zero latency. A requester that is valid in an IDLE cycle and selected is accepted that same cycle.
- Back-to-back: with both requesters continuously valid, grants alternate 0,1,0,1 with one accept per period.
- No bubble beyond the single IDLE accept cycle.

## Test plan
- Reset: hold rst=1 for 2 cycles with both valid=1 → outputs 0, busy=0, both ready=0. On the first cycle after rst=0, req0_ready=1.
- Single write: req0 rs=1 data=0x39 accepted at t → LCD_RS=1, LCD_DATA=0x39 from t+1; LCD_E=1 exactly t+3..t+6; busy falls after t+48; LCD_RW=0 throughout.
- Tie and round-robin: req0 (0x41) and req1 (0x42) valid from reset → accepts req0, req1, req0 at t, t+49, t+98; grant_id 0,1,0; LCD_DATA 0x41, 0x42, 0x41.
- Clear wait: req1 rs=0 data=0x01 → busy for 168 cycles. A req0 rs=0 data=0x0F queued during this time is accepted at t+169 and gets only a 40-cycle wait.
- Late arrival: req1 asserts valid at t+10 during req0's write → req1_ready stays 0 until t+49, then accepted at t+49.
- Reset mid-pulse: assert rst in cycle t+4 → at t+5 LCD_E=0, LCD_DATA=0x00, busy=0. With no valid after rst deasserts, no E pulse occurs.
